regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-side controller for the 32-entry register file.
- Merges single-cycle ALU results and long-latency LSU/mul-div results, buffers the latter in a small FIFO, and drives the register file's single write port (rd_addr/rd_data/reg_we) from registered outputs.
- Keeps a pending-write scoreboard so the issue stage can stall on RAW hazards against registers with writes still in flight.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register index width.
- FIFO_DEPTH, 2, long-latency result buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result present.
- alu_rd  in  ADDR_WIDTH  ALU destination.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- lsu_valid  in  1  long-latency result present.
- lsu_rd  in  ADDR_WIDTH  long-latency destination.
- lsu_data  in  DATA_WIDTH  long-latency result.
- lsu_ready  out  1  FIFO can accept (not full).
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  ADDR_WIDTH  its destination.
- rs1_addr, rs2_addr  in  ADDR_WIDTH  hazard query addresses.
- rs1_busy, rs2_busy  out  1  queried register has a write outstanding.
- rd_addr  out  ADDR_WIDTH  register file write address.
- rd_data  out  DATA_WIDTH  register file write data.
- reg_we  out  1  register file write enable.

Behaviour:
- Reset: FIFO empty; scoreboard all zero; rd_addr=0, rd_data=0, reg_we=0. This gives alu_ready=1 and lsu_ready=1 after reset. Reset mid-operation drops all buffered and pending writes.
- Handshakes:
  - ALU transfer when alu_valid && alu_ready.
  - LSU push when lsu_valid && lsu_ready.
  - lsu_ready = !full, combinational from registered state only. Pushing while full is impossible; a simultaneous pop does not make room that cycle.
- Arbitration per cycle, one winner:
  - FIFO full and nonempty: FIFO head wins, alu_ready=0 (starvation guard).
  - Else ALU valid: ALU wins, alu_ready=1.
  - Else FIFO head (if nonempty) is popped.
  - alu_ready=1 whenever FIFO not full.
- Output stage: registered, one-cycle latency. On the next edge after the winner is selected: rd_addr/rd_data = winner, reg_we = 1 if the winner's rd != 0, else 0. With no winner, reg_we=0 and rd_addr/rd_data hold their previous values.
- rd=0 results are accepted and consumed normally but never assert reg_we.
- FIFO:
  - Circular buffer with read/write pointers wrapping at FIFO_DEPTH, plus a count.
  - Push and pop in the same cycle leaves count unchanged.
  - A push into an empty FIFO is not poppable until the next cycle (no bypass).
- Scoreboard, pending[31:1]:
  - Set on issue_valid && issue_rd != 0.
  - Cleared when the FIFO head with that rd is popped.
  - Set and clear of the same index in one cycle: set wins.
  - issue_valid for an already-pending rd is illegal (assertion); state stays set.
- Busy:
  - rsN_busy = pending[rsN_addr] || (reg_we && rd_addr == rsN_addr).
  - Forced to 0 when rsN_addr == 0.
  - Purely combinational from registered state.
- Throughput: one register write per cycle maximum. The ALU is delayed only while the FIFO is full.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, NUM_REGS=32, and the zero-register index constant.
- One sub-module, wb_fifo (parameterised width = ADDR_WIDTH+DATA_WIDTH, depth FIFO_DEPTH; ports push/pop/full/empty/head).
- Arbitration, scoreboard and output register stay in regfile_wb_ctrl.

Test Plan:
- Reset with all inputs idle -> reg_we=0, rd_addr=0, alu_ready=1, lsu_ready=1, rs1_busy=0 for every rs1_addr.
- alu_valid, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> next cycle reg_we=1, rd_addr=5, rd_data=0xDEADBEEF; rs1_addr=5 shows busy=1 only in that cycle.
- issue_valid, issue_rd=7; three cycles later lsu_valid, rd=7, data=0x1234 with ALU idle -> rs1_busy(7)=1 from the cycle after issue until the pop; write of 0x1234 to x7 appears two cycles after the push; busy drops the cycle after the write.
- Continuous alu_valid while pushing three LSU results (rd=1,2,3) -> FIFO fills at 2 and lsu_ready=0; the next cycle alu_ready=0 and head rd=1 is written. Writes occur in order 1,2,3 interleaved with ALU writes, none lost.
- alu_rd=0 and lsu_rd=0 results -> accepted (ready high), reg_we stays 0, FIFO drains.
- rst_n asserted while FIFO holds 2 entries and pending[9]=1 -> immediately reg_we=0, lsu_ready=1, rs1_busy(9)=0; no buffered write appears after release.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_ctrl_pkg
// Shared definitions for the register-file write-back controller: default
// data/index widths, register count, the hard-wired zero register index and
// the write-port winner selector.
// ----------------------------------------------------------------------------
package regfile_wb_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS       = 32;

    localparam logic [ADDR_WIDTH_DEF-1:0] ZERO_REG = '0;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small circular buffer for long-latency write-back results.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data enqueue request and entry (ignored while full)
//   pop             dequeue request (ignored while empty)
//   full, empty     status, decoded from the registered count
//   head            oldest entry (registered storage, no push bypass)
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers advance by one and wrap at DEPTH; a simultaneous push and pop
    // leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_wb_ctrl
// Write-side controller for the 32-entry register file. Merges single-cycle
// ALU results with buffered long-latency (LSU/mul-div) results onto the single
// registered write port and tracks in-flight long-latency destinations so the
// issue stage can stall on RAW hazards.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     ALU result; alu_ready = accepted this cycle
//   lsu_valid/lsu_rd/lsu_data     long-latency result; lsu_ready = FIFO not full
//   issue_valid/issue_rd          long-latency op issued, marks rd pending
//   rs1_addr/rs2_addr             hazard query addresses
//   rs1_busy/rs2_busy             queried register has a write outstanding
//   rd_addr/rd_data/reg_we        registered register-file write port
// ----------------------------------------------------------------------------
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  reg_we
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    wb_src_e               win_src;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    logic [NUM_REGS-1:0]   pending;

    assign {head_rd, head_data} = fifo_head;

    // Ready depends only on the registered fill level, so a pop in the same
    // cycle never makes room for a push.
    assign lsu_ready = !fifo_full;
    assign fifo_push = lsu_valid && !fifo_full;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({lsu_rd, lsu_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // One winner per cycle. A full FIFO takes priority over the ALU so the
    // long-latency path cannot be starved; otherwise the ALU goes first and
    // the FIFO drains in idle ALU cycles.
    always_comb begin
        win_src   = SRC_NONE;
        alu_ready = 1'b1;
        win_rd    = head_rd;
        win_data  = head_data;
        if (fifo_full) begin
            win_src   = SRC_FIFO;
            alu_ready = 1'b0;
        end else if (alu_valid) begin
            win_src  = SRC_ALU;
            win_rd   = alu_rd;
            win_data = alu_data;
        end else if (!fifo_empty) begin
            win_src = SRC_FIFO;
        end
    end

    assign fifo_pop = (win_src == SRC_FIFO);

    // Write port register. Results for x0 are consumed and still update the
    // address/data fields, but never raise the write enable. Idle cycles hold
    // address and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (win_src != SRC_NONE) begin
            reg_we  <= (win_rd != ZERO_IDX);
            rd_addr <= win_rd;
            rd_data <= win_data;
        end else begin
            reg_we  <= 1'b0;
        end
    end

    // Pending-write scoreboard. A new issue to a register overrides a
    // completion to the same register in the same cycle. Entry 0 never
    // becomes pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending[0] <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (issue_valid && (issue_rd == ADDR_WIDTH'(i))) begin
                    pending[i] <= 1'b1;
                end else if (fifo_pop && (head_rd == ADDR_WIDTH'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // A register is busy while its long-latency write is outstanding or while
    // the write port is committing to it this cycle.
    assign rs1_busy = (rs1_addr != ZERO_IDX) &&
                      (pending[rs1_addr] || (reg_we && (rd_addr == rs1_addr)));
    assign rs2_busy = (rs2_addr != ZERO_IDX) &&
                      (pending[rs2_addr] || (reg_we && (rd_addr == rs2_addr)));

    // Issuing to a register that already has a write in flight is illegal.
    a_no_double_issue: assert property (
        @(posedge clk) disable iff (!rst_n)
        (issue_valid && (issue_rd != ZERO_IDX)) |-> !pending[issue_rd]
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Directed bench for regfile_wb_ctrl with a queue-based reference model and
// a per-cycle compare process, plus hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          lsu_ready;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic [AW-1:0] rs1_addr = '0;
    logic [AW-1:0] rs2_addr = '0;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          reg_we;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .reg_we      (reg_we)
    );

    always #5 clk = ~clk;

    // Reference model: buffered results as a queue, pending set as a flag
    // array, and the expected write-port contents.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    bit            m_pend[32];
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    int            we_seen = 0;
    logic [AW-1:0] lsu_order[$];

    function automatic logic m_busy(input logic [AW-1:0] a);
        return (a != 0) && (m_pend[a] || (m_we && (m_addr == a)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        ent_t w;
        bit   have;
        bit   was_full;
        if (!rst_n) begin
            mq.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            have     = 1'b0;
            was_full = (mq.size() == DEPTH);
            if (was_full || (!alu_valid && mq.size() > 0)) begin
                w = mq.pop_front();
                have = 1'b1;
                m_pend[w.rd] = 1'b0;
            end else if (alu_valid) begin
                w.rd   = alu_rd;
                w.data = alu_data;
                have   = 1'b1;
            end
            if (lsu_valid && !was_full) begin
                mq.push_back('{rd: lsu_rd, data: lsu_data});
            end
            if (issue_valid && issue_rd != 0) begin
                m_pend[issue_rd] = 1'b1;
            end
            if (have) begin
                m_addr = w.rd;
                m_data = w.data;
                m_we   = (w.rd != 0);
            end else begin
                m_we   = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput("reg_we",    64'(reg_we),    64'(m_we));
        checkOutput("rd_addr",   64'(rd_addr),   64'(m_addr));
        checkOutput("rd_data",   64'(rd_data),   64'(m_data));
        checkOutput("alu_ready", 64'(alu_ready), 64'(mq.size() < DEPTH));
        checkOutput("lsu_ready", 64'(lsu_ready), 64'(mq.size() < DEPTH));
        checkOutput("rs1_busy",  64'(rs1_busy),  64'(m_busy(rs1_addr)));
        checkOutput("rs2_busy",  64'(rs2_busy),  64'(m_busy(rs2_addr)));
        if (reg_we) begin
            we_seen++;
            if (rd_addr >= 1 && rd_addr <= 3) lsu_order.push_back(rd_addr);
        end
    end

    task automatic applyStimulus(input logic av, input logic [AW-1:0] ar,
                                 input logic [DW-1:0] ad, input logic lv,
                                 input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                                 input logic iv, input logic [AW-1:0] ir);
        alu_valid   = av;
        alu_rd      = ar;
        alu_data    = ad;
        lsu_valid   = lv;
        lsu_rd      = lr;
        lsu_data    = ld;
        issue_valid = iv;
        issue_rd    = ir;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            alu_k;
        int            lsu_k;
        bit            acc_a;
        bit            acc_l;
        int            we_before;
        logic [14:0]   order_val;

        // Reset with idle inputs; sweep every query address while held.
        idle();
        #12;
        checkOutput("rst_reg_we",    64'(reg_we),    64'd0);
        checkOutput("rst_rd_addr",   64'(rd_addr),   64'd0);
        checkOutput("rst_alu_ready", 64'(alu_ready), 64'd1);
        checkOutput("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = AW'(a);
            #1;
            checkOutput("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        end
        rs1_addr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single ALU write to x5.
        rs1_addr = 5'd5;
        rs2_addr = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
        #1;
        checkOutput("alu_busy_before", 64'(rs1_busy), 64'd0);
        tick();
        idle();
        #1;
        checkOutput("alu_we",      64'(reg_we),   64'd1);
        checkOutput("alu_addr",    64'(rd_addr),  64'd5);
        checkOutput("alu_data",    64'(rd_data),  64'hDEADBEEF);
        checkOutput("alu_busy_wr", 64'(rs1_busy), 64'd1);
        tick();
        checkOutput("alu_busy_after", 64'(rs1_busy), 64'd0);
        checkOutput("alu_we_after",   64'(reg_we),   64'd0);

        // Long-latency op to x7: busy from issue until the write retires.
        rs1_addr = 5'd7;
        rs2_addr = 5'd0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        tick();
        idle();
        #1;
        checkOutput("ll_busy_issue", 64'(rs1_busy), 64'd1);
        tick();
        checkOutput("ll_busy_wait1", 64'(rs1_busy), 64'd1);
        tick();
        checkOutput("ll_busy_wait2", 64'(rs1_busy), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234, 1'b0, '0);
        tick();
        idle();
        #1;
        checkOutput("ll_we_push", 64'(reg_we),   64'd0);
        checkOutput("ll_busy_q",  64'(rs1_busy), 64'd1);
        tick();
        checkOutput("ll_we",      64'(reg_we),   64'd1);
        checkOutput("ll_addr",    64'(rd_addr),  64'd7);
        checkOutput("ll_data",    64'(rd_data),  64'h1234);
        checkOutput("ll_busy_wr", 64'(rs1_busy), 64'd1);
        tick();
        checkOutput("ll_busy_done", 64'(rs1_busy), 64'd0);

        // Continuous ALU traffic while three LSU results arrive.
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        alu_k = 0;
        lsu_k = 0;
        lsu_order.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            applyStimulus(alu_k < 4, AW'(10 + alu_k), 32'hA000_0000 + 32'(alu_k),
                          lsu_k < 3, AW'(1 + lsu_k), 32'h5000_0000 + 32'(lsu_k),
                          1'b0, '0);
            #1;
            if (cyc == 2) begin
                checkOutput("fill_lsu_ready", 64'(lsu_ready), 64'd0);
                checkOutput("fill_alu_ready", 64'(alu_ready), 64'd0);
            end
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            tick();
            if (acc_a) alu_k++;
            if (acc_l) lsu_k++;
            if (cyc == 2) begin
                checkOutput("fill_head_we",   64'(reg_we),  64'd1);
                checkOutput("fill_head_rd",   64'(rd_addr), 64'd1);
                checkOutput("fill_head_data", 64'(rd_data), 64'h5000_0000);
            end
        end
        idle();
        checkOutput("fill_alu_done", 64'(alu_k), 64'd4);
        order_val = '0;
        foreach (lsu_order[i]) order_val = {order_val[9:0], lsu_order[i]};
        checkOutput("fill_order_cnt", 64'(lsu_order.size()), 64'd3);
        checkOutput("fill_order", 64'(order_val), 64'({5'd1, 5'd2, 5'd3}));

        // x0 results: accepted, consumed, never written.
        applyStimulus(1'b1, 5'd0, 32'h0000_AAAA, 1'b1, 5'd0, 32'h0000_BBBB, 1'b0, '0);
        #1;
        checkOutput("x0_alu_ready", 64'(alu_ready), 64'd1);
        checkOutput("x0_lsu_ready", 64'(lsu_ready), 64'd1);
        tick();
        idle();
        #1;
        checkOutput("x0_alu_we",   64'(reg_we),  64'd0);
        checkOutput("x0_alu_data", 64'(rd_data), 64'h0000_AAAA);
        tick();
        checkOutput("x0_lsu_we",   64'(reg_we),  64'd0);
        checkOutput("x0_lsu_data", 64'(rd_data), 64'h0000_BBBB);
        tick();

        // Reset while the FIFO holds two entries and x9 is pending.
        rs1_addr = 5'd9;
        rs2_addr = 5'd12;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        tick();
        applyStimulus(1'b1, 5'd20, 32'h2020, 1'b1, 5'd9, 32'h9999, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 5'd21, 32'h2121, 1'b1, 5'd12, 32'hC0C0, 1'b0, '0);
        tick();
        idle();
        #1;
        checkOutput("mid_full",      64'(lsu_ready), 64'd0);
        checkOutput("mid_busy9",     64'(rs1_busy),  64'd1);
        checkOutput("mid_we",        64'(reg_we),    64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_we",        64'(reg_we),    64'd0);
        checkOutput("rst2_lsu_ready", 64'(lsu_ready), 64'd1);
        checkOutput("rst2_busy9",     64'(rs1_busy),  64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        we_before = we_seen;
        repeat (5) tick();
        checkOutput("rst2_no_stale_we", 64'(we_seen - we_before), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
